// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with configurable width, parity and stop bits
module uart_rx_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 busy
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int M   = OVERSAMPLE / 2;
  localparam logic [SW-1:0] LO_S  = SW'(M - 1);
  localparam logic [SW-1:0] MID_S = SW'(M);
  localparam logic [SW-1:0] RES_S = SW'(M + 1);
  localparam logic [SW-1:0] END_S = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        s_q, s_d;
  logic [1:0]           smp_q, smp_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pbit_q, pbit_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 stop1_q, stop1_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 break_q, break_d;
  logic                 rxs, tick, res, wrap, maj, brk;

  // next-state: tick generation, majority sampling, frame FSM and completion registers
  always_comb begin
    sync_d = {sync_q[0], rxd};
    rxs = sync_q[1];
    tick = cnt_q == CW'(DIV - 1);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    res = tick && s_q == RES_S;
    wrap = tick && s_q == END_S;
    maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    smp_d = smp_q;
    if (tick && s_q == LO_S) smp_d[0] = rxs;
    if (tick && s_q == MID_S) smp_d[1] = rxs;
    s_d = tick ? ((state_q == S_IDLE) ? {{(SW-1){1'b0}}, !rxs} : (wrap ? '0 : s_q + SW'(1))) : s_q;
    state_d = state_q;
    bcnt_d = bcnt_q;
    shift_d = shift_q;
    pbit_d = pbit_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    stop1_d = stop1_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    frame_err_d = frame_err_q;
    parity_err_d = parity_err_q;
    break_d = break_q;
    brk = 1'b0;
    case (state_q)
      S_IDLE: if (tick && !rxs) begin
        state_d = S_START;
        bcnt_d = '0;
        pbit_d = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        stop1_d = 1'b0;
      end
      S_START: begin
        if (res && maj) state_d = S_IDLE;
        else if (wrap) state_d = S_DATA;
      end
      S_DATA: begin
        if (res) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          bcnt_d = bcnt_q + BW'(1);
        end
        if (wrap && bcnt_d == BW'(DATA_BITS)) begin
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
          bcnt_d = '0;
        end
      end
      S_PAR: begin
        if (res) begin
          pbit_d = maj;
          perr_d = maj != ((PARITY == 1) ? ~^shift_q : ^shift_q);
        end
        if (wrap) state_d = S_STOP;
      end
      S_STOP: if (res) begin
        ferr_d = ferr_q | !maj;
        stop1_d = stop1_q | maj;
        bcnt_d = bcnt_q + BW'(1);
        if (bcnt_q == BW'(STOP_BITS - 1)) begin
          brk = (shift_q == '0) && !pbit_q && !(stop1_q | maj);
          rx_valid_d = 1'b1;
          rx_data_d = shift_q;
          frame_err_d = ferr_q | !maj;
          parity_err_d = perr_q;
          break_d = brk;
          state_d = brk ? S_BRK : S_IDLE;
        end
      end
      S_BRK: if (tick && rxs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) s_d = '0;
  end

  // state and output registers, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync_q <= 2'b11;
      cnt_q <= '0;
      s_q <= '0;
      smp_q <= '0;
      bcnt_q <= '0;
      shift_q <= '0;
      pbit_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      stop1_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      parity_err_q <= 1'b0;
      break_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      s_q <= s_d;
      smp_q <= smp_d;
      bcnt_q <= bcnt_d;
      shift_q <= shift_d;
      pbit_q <= pbit_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      stop1_q <= stop1_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frame_err_q <= frame_err_d;
      parity_err_q <= parity_err_d;
      break_q <= break_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign frame_err = frame_err_q;
  assign parity_err = parity_err_q;
  assign break_det = break_q;
  assign busy = state_q != S_IDLE;
endmodule
